// File: rtl/qam_pkg.sv
// Shared QPSK/4-QAM constants: sample/product widths, decision polarity and bit order.
package qam_pkg;
    localparam int SAMPLE_W = 16;
    localparam int PROD_W   = 32;

    // Decision bit produced for a non-negative arm sum (1 = positive carrier).
    localparam logic DECIDE_POS = 1'b1;

    // Symbol bit positions: MSB carries the sine arm and is sent first.
    localparam int SIN_BIT = 1;
    localparam int COS_BIT = 0;

    function automatic logic decide(input logic sum_sign);
        return sum_sign ? ~DECIDE_POS : DECIDE_POS;
    endfunction
endpackage

// File: rtl/integrate_dump.sv
// One correlator arm: integrate registered products over a symbol, then sign-decide.
module integrate_dump
    import qam_pkg::*;
#(
    parameter int SAMPLE_W = qam_pkg::SAMPLE_W,
    parameter int ACC_W    = 38
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [2*SAMPLE_W-1:0] product,
    input  logic                        p_vld,
    input  logic                        p_first,
    input  logic                        p_last,
    output logic                        dec,
    output logic                        dec_stb
);
    localparam int P_W = 2 * SAMPLE_W;

    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] sum;

    // A first sample restarts the integration, which also drops any partial symbol on resync.
    always_comb begin
        sum = (p_first ? '0 : acc_reg) + {{(ACC_W-P_W){product[P_W-1]}}, product};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            dec     <= 1'b0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= p_vld & p_last;
            if (p_vld) begin
                acc_reg <= sum;
                if (p_last) begin
                    dec <= decide(sum[ACC_W-1]);
                end
            end
        end
    end
endmodule

// File: rtl/qam_demod.sv
// Coherent QPSK receiver: mix with sin/cos references, integrate per symbol, decide, re-serialise.
module qam_demod
    import qam_pkg::*;
#(
    parameter int SPS   = 32,
    parameter int CNT_W = $clog2(SPS),
    parameter int ACC_W = 32 + $clog2(SPS) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] mixed_in,
    input  logic signed [SAMPLE_W-1:0] sine_ref,
    input  logic signed [SAMPLE_W-1:0] cosine_ref,
    input  logic                       sym_sync,
    output logic [1:0]                 elojel_sin_cos,
    output logic                       sym_valid,
    output logic                       adat_ki,
    output logic                       bit_valid
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SPS - 1);

    logic [CNT_W-1:0]         cnt_reg;
    logic [CNT_W-1:0]         idx;
    logic signed [PROD_W-1:0] p_s_reg;
    logic signed [PROD_W-1:0] p_c_reg;
    logic                     p_vld_reg;
    logic                     p_first_reg;
    logic                     p_last_reg;
    logic                     next_bit_reg;
    logic                     pend_reg;

    logic signed [PROD_W-1:0] prod_w [2];
    logic [1:0]               dec_w;
    logic [1:0]               stb_w;

    always_comb begin
        idx = sym_sync ? '0 : cnt_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            p_s_reg     <= '0;
            p_c_reg     <= '0;
            p_vld_reg   <= 1'b0;
            p_first_reg <= 1'b0;
            p_last_reg  <= 1'b0;
        end else begin
            p_vld_reg <= en;
            if (en) begin
                p_s_reg     <= PROD_W'(mixed_in) * PROD_W'(sine_ref);
                p_c_reg     <= PROD_W'(mixed_in) * PROD_W'(cosine_ref);
                p_first_reg <= (idx == '0);
                p_last_reg  <= (idx == LAST_IDX);
                cnt_reg     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    assign prod_w[SIN_BIT] = p_s_reg;
    assign prod_w[COS_BIT] = p_c_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arm
            integrate_dump #(
                .SAMPLE_W (SAMPLE_W),
                .ACC_W    (ACC_W)
            ) u_arm (
                .clk     (clk),
                .rst     (rst),
                .product (prod_w[gi]),
                .p_vld   (p_vld_reg),
                .p_first (p_first_reg),
                .p_last  (p_last_reg),
                .dec     (dec_w[gi]),
                .dec_stb (stb_w[gi])
            );
        end
    endgenerate

    assign elojel_sin_cos = dec_w;
    assign sym_valid      = &stb_w;

    // The sine bit leaves on the clk right after the load; the cosine bit waits one more clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adat_ki      <= 1'b0;
            bit_valid    <= 1'b0;
            next_bit_reg <= 1'b0;
            pend_reg     <= 1'b0;
        end else if (sym_valid) begin
            adat_ki      <= elojel_sin_cos[SIN_BIT];
            next_bit_reg <= elojel_sin_cos[COS_BIT];
            bit_valid    <= 1'b1;
            pend_reg     <= 1'b1;
        end else if (pend_reg) begin
            adat_ki   <= next_bit_reg;
            bit_valid <= 1'b1;
            pend_reg  <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_qam_demod.sv
// Directed + randomized bench for qam_demod against a cycle-scheduled symbol-level reference model.
module tb_qam_demod;
    localparam int  SPS  = 32;
    localparam int  MAXE = 16384;
    localparam real PI   = 3.14159265358979;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              sym_sync = 1'b0;
    logic signed [15:0] mixed_in = '0;
    logic signed [15:0] sine_ref = '0;
    logic signed [15:0] cosine_ref = '0;
    logic [1:0]        elojel_sin_cos;
    logic              sym_valid;
    logic              adat_ki;
    logic              bit_valid;

    qam_demod #(.SPS(SPS)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .mixed_in       (mixed_in),
        .sine_ref       (sine_ref),
        .cosine_ref     (cosine_ref),
        .sym_sync       (sym_sync),
        .elojel_sin_cos (elojel_sin_cos),
        .sym_valid      (sym_valid),
        .adat_ki        (adat_ki),
        .bit_valid      (bit_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: symbol position, exact 64-bit arm sums, and per-edge expected events.
    int         edge_n = 0;
    int         pos = 0;
    longint     sum_s = 0;
    longint     sum_c = 0;
    bit         exp_sv [MAXE];
    logic [1:0] exp_sym [MAXE];
    bit         exp_bv [MAXE];
    bit         exp_bit [MAXE];
    logic [1:0] hold_sym = 2'b00;
    logic       hold_bit = 1'b0;
    int         n_sym_exp = 0;
    int         n_sym_obs = 0;

    function automatic int sref(int n);
        return $rtoi($floor(16383.0 * $sin(2.0 * PI * real'(n) / real'(SPS)) + 0.5));
    endfunction

    function automatic int cref(int n);
        return $rtoi($floor(16383.0 * $cos(2.0 * PI * real'(n) / real'(SPS)) + 0.5));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, edge_n);
        end
    endtask

    task automatic check_outputs();
        if (edge_n < MAXE) begin
            if (exp_sv[edge_n]) begin
                hold_sym = exp_sym[edge_n];
                n_sym_exp++;
            end
            if (exp_bv[edge_n]) hold_bit = exp_bit[edge_n];
            check("sym_valid", 64'(sym_valid), 64'(exp_sv[edge_n]));
            check("elojel_sin_cos", 64'(elojel_sin_cos), 64'(hold_sym));
            check("bit_valid", 64'(bit_valid), 64'(exp_bv[edge_n]));
            check("adat_ki", 64'(adat_ki), 64'(hold_bit));
        end
        if (sym_valid) n_sym_obs++;
    endtask

    // Drive one clk of inputs (called at a negedge), update the model, then check after the edge.
    task automatic step(input bit e, input int m, input int s, input int c, input bit sy);
        logic [1:0] d;
        int         ev;
        en = e;
        mixed_in = 16'(m);
        sine_ref = 16'(s);
        cosine_ref = 16'(c);
        sym_sync = sy;
        if (e) begin
            if (sy) pos = 0;
            if (pos == 0) begin
                sum_s = 0;
                sum_c = 0;
            end
            sum_s += longint'(m) * longint'(s);
            sum_c += longint'(m) * longint'(c);
            if (pos == SPS - 1) begin
                ev = edge_n + 1;
                d = {(sum_s >= 0), (sum_c >= 0)};
                if (ev + 3 < MAXE) begin
                    exp_sv[ev + 1]  = 1'b1;
                    exp_sym[ev + 1] = d;
                    exp_bv[ev + 2]  = 1'b1;
                    exp_bit[ev + 2] = d[1];
                    exp_bv[ev + 3]  = 1'b1;
                    exp_bit[ev + 3] = d[0];
                end
                pos = 0;
            end else begin
                pos++;
            end
        end
        @(posedge clk);
        #1;
        edge_n++;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0);
    endtask

    // One loopback symbol: mixed = ss*sin + cs*cos, with 'gap' idle clks after each en.
    task automatic sym_tx(input int ss, input int cs, input int gap);
        for (int n = 0; n < SPS; n++) begin
            step(1'b1, ss * sref(n) + cs * cref(n), sref(n), cref(n), 1'b0);
            idle(gap);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without waiting for clk.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_elojel", 64'(elojel_sin_cos), 64'd0);
        check("rst_async_sym_valid", 64'(sym_valid), 64'd0);
        check("rst_async_adat_ki", 64'(adat_ki), 64'd0);
        check("rst_async_bit_valid", 64'(bit_valid), 64'd0);
        for (int i = edge_n + 1; i < MAXE; i++) begin
            exp_sv[i] = 1'b0;
            exp_bv[i] = 1'b0;
        end
        hold_sym = 2'b00;
        hold_bit = 1'b0;
        pos = 0;
        @(posedge clk);
        #1;
        edge_n++;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MAXE; i++) begin
            exp_sv[i] = 1'b0;
            exp_bv[i] = 1'b0;
            exp_sym[i] = 2'b00;
            exp_bit[i] = 1'b0;
        end

        // Power-on reset
        @(negedge clk);
        check("reset_elojel", 64'(elojel_sin_cos), 64'd0);
        check("reset_sym_valid", 64'(sym_valid), 64'd0);
        check("reset_adat_ki", 64'(adat_ki), 64'd0);
        check("reset_bit_valid", 64'(bit_valid), 64'd0);
        rst = 1'b0;
        idle(2);

        // Loopback with en every clk: sin+cos -> 11, sin-cos -> 10
        sym_tx(1, 1, 0);
        sym_tx(1, -1, 0);
        idle(5);

        // All four symbols back-to-back with en every 4th clk
        sym_tx(1, 1, 3);
        sym_tx(1, -1, 3);
        sym_tx(-1, 1, 3);
        sym_tx(-1, -1, 3);
        idle(5);

        // Zero input: tie decides 11
        for (int n = 0; n < SPS; n++) step(1'b1, 0, sref(n), cref(n), 1'b0);
        idle(5);

        // Full scale: no accumulator wrap, expect 10
        for (int n = 0; n < SPS; n++) step(1'b1, 32767, 32767, -32768, 1'b0);
        idle(5);

        // Resync at index 10 drops the partial symbol; the new one is a full SPS long
        for (int n = 0; n < 10; n++) step(1'b1, -sref(n) - cref(n), sref(n), cref(n), 1'b0);
        for (int n = 0; n < SPS; n++) step(1'b1, sref(n) - cref(n), sref(n), cref(n), n == 0);
        idle(5);

        // sym_sync without en is ignored
        for (int n = 0; n < SPS; n++) begin
            if (n == 5) step(1'b0, 0, 0, 0, 1'b1);
            step(1'b1, -sref(n) + cref(n), sref(n), cref(n), 1'b0);
        end
        idle(5);

        // Leave 11 on the outputs, then reset at index 10 of the next symbol
        sym_tx(1, 1, 0);
        idle(5);
        for (int n = 0; n < 10; n++) step(1'b1, -sref(n) - cref(n), sref(n), cref(n), 1'b0);
        async_reset();
        sym_tx(-1, 1, 0);
        idle(5);

        // Randomized samples, strobe spacing and occasional resyncs
        for (int k = 0; k < 24 * SPS; k++) begin
            int m, s, c;
            bit sy;
            m = int'($signed(16'($urandom)));
            s = int'($signed(16'($urandom)));
            c = int'($signed(16'($urandom)));
            sy = ($urandom_range(0, 60) == 0);
            step(1'b1, m, s, c, sy);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 80) == 0) step(1'b0, 0, 0, 0, 1'b1);
        end
        idle(6);

        check("sym_valid_count", 64'(n_sym_obs), 64'(n_sym_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
